// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift sequencer FSM states, shift direction encodings
// and the default datapath width.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    localparam int ALU_WIDTH = 4;

endpackage

// File: rtl/alu_shift_sequencer_shift_step.sv
// One-bit shift/rotate datapath register: parallel load, or a single-position
// step toward MSB or LSB on each enabled cycle.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable_sh,
    input  logic             reg_sh,
    input  logic             rot,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;
    logic             fill_msb_s;
    logic             fill_lsb_s;

    // Bit entering the vacated end: wrapped-around bit when rotating, else zero
    always_comb begin
        fill_lsb_s = 1'b0;
        fill_msb_s = 1'b0;
        if (rot) begin
            fill_lsb_s = q_r[WIDTH-1];
            fill_msb_s = q_r[0];
        end else begin
            fill_lsb_s = 1'b0;
            fill_msb_s = 1'b0;
        end
    end

    // Datapath register: load has priority over a shift step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= load_data;
        end else if (enable_sh && (reg_sh == DIR_LEFT)) begin
            q_r <= {q_r[WIDTH-2:0], fill_lsb_s};
        end else if (enable_sh && (reg_sh == DIR_RIGHT)) begin
            q_r <= {fill_msb_s, q_r[WIDTH-1:1]};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift sequencer: accepts one request, steps the shift_step datapath
// once per cycle, then presents the result until taken.
// Optional rotate support is enabled with macro ALU_SHIFT_ROTATE_EN.
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
    input  logic             req_rot,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    shift_state_e     state_r, state_n;
    logic [AMT_W-1:0] cnt_r, cnt_n;
    logic             dir_r, dir_n;
    logic             rot_r, rot_n;
    logic             rot_req_s;
    logic [AMT_W-1:0] amt_eff_s;
    logic             load_s;
    logic             enable_s;

    // Rotation wraps modulo WIDTH; zero-fill saturates at WIDTH (result all zeros)
    function automatic logic [AMT_W-1:0] eff_amt(input logic [AMT_W-1:0] amt,
                                                  input logic rot);
        logic [AMT_W-1:0] res;
        if (rot) begin
            res = amt % AMT_W'(WIDTH);
        end else if (amt >= AMT_W'(WIDTH)) begin
            res = AMT_W'(WIDTH);
        end else begin
            res = amt;
        end
        return res;
    endfunction

`ifdef ALU_SHIFT_ROTATE_EN
    assign rot_req_s = req_rot;
`else
    logic unused_rot_s;
    assign unused_rot_s = req_rot;
    assign rot_req_s    = 1'b0;
`endif

    assign amt_eff_s = eff_amt(req_amt, rot_req_s);

    // Next-state, step counter and datapath control
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        dir_n    = dir_r;
        rot_n    = rot_r;
        load_s   = 1'b0;
        enable_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    load_s = 1'b1;
                    dir_n  = req_dir;
                    rot_n  = rot_req_s;
                    cnt_n  = amt_eff_s;
                    if (amt_eff_s == AMT_W'(0)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_SHIFT;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                enable_s = 1'b1;
                cnt_n    = cnt_r - AMT_W'(1);
                if (cnt_r == AMT_W'(1)) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            dir_r   <= DIR_RIGHT;
            rot_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            dir_r   <= dir_n;
            rot_r   <= rot_n;
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (req_data),
        .enable_sh (enable_s),
        .reg_sh    (dir_r),
        .rot       (rot_r),
        .q         (res_data)
    );

    assign req_ready = (state_r == ST_IDLE);
    assign res_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer (WIDTH=4) using a result scoreboard.
`timescale 1ns/1ps
module tb_alu_shift_sequencer;

    localparam int W     = 4;
    localparam int AMT_W = 3;
`ifdef ALU_SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [W-1:0]     req_data = '0;
    logic [AMT_W-1:0] req_amt = '0;
    logic             req_dir = 1'b0;
    logic             req_rot = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [W-1:0]     res_data;
    logic             busy;

    typedef struct {
        logic [W-1:0] data;
        int           lat;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    alu_shift_sequencer #(.WIDTH(W), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .req_rot   (req_rot),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input int amt,
                                                input logic dir, input logic rot);
        logic [2*W-1:0] dd;
        logic [2*W-1:0] sh;
        int a;
        if (ROT_EN && rot) begin
            a  = amt % W;
            dd = {d, d};
            if (dir) begin
                sh = dd << a;
                return sh[2*W-1:W];
            end
            sh = dd >> a;
            return sh[W-1:0];
        end
        if (amt >= W) return '0;
        return dir ? (d << amt) : (d >> amt);
    endfunction

    function automatic int model_lat(input int amt, input logic rot);
        if (ROT_EN && rot) return 1 + (amt % W);
        return 1 + ((amt >= W) ? W : amt);
    endfunction

    task automatic send(input logic [W-1:0] d, input int amt, input logic dir, input logic rot);
        int n = 0;
        while (req_ready !== 1'b1 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = AMT_W'(amt);
        req_dir   = dir;
        req_rot   = rot;
        sb.push_back('{model_data(d, amt, dir, rot), model_lat(amt, rot)});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = W'($urandom);
        req_amt   = AMT_W'($urandom);
        req_dir   = 1'($urandom);
    endtask

    task automatic wait_result(input int start, output logic [W-1:0] d, output int lat);
        lat = start;
        while (res_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (res_valid !== 1'b1) lat = -1;
        d = res_data;
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%b busy=%b, required 1 0 0000 0",
                     req_ready, res_valid, res_data, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_case(input string name, input logic [W-1:0] d, input int amt,
                             input logic dir, input logic rot);
        logic [W-1:0] od;
        int ol;
        exp_t e;
        send(d, amt, dir, rot);
        wait_result(1, od, ol);
        e = sb.pop_front();
        checks++;
        if (od !== e.data) begin
            errors++;
            $display("FAIL %s_data: got %b, required %b", name, od, e.data);
        end
        checks++;
        if (ol !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required %0d", name, ol, e.lat);
        end
        take();
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: valid=%b ready=%b, required 0 1", name, res_valid, req_ready);
        end
    endtask

    task automatic test_shift_right_busy();
        logic [W-1:0] od;
        int ol;
        exp_t e;
        send(4'b1000, 3, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (busy !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL right_busy_T+%0d: busy=%b valid=%b, required 1 0", k, busy, res_valid);
            end
            @(posedge clk); #1;
        end
        wait_result(4, od, ol);
        e = sb.pop_front();
        checks++;
        if (od !== e.data || ol !== e.lat || busy !== 1'b1) begin
            errors++;
            $display("FAIL right_result: data=%b lat=%0d busy=%b, required %b %0d 1",
                     od, ol, busy, e.data, e.lat);
        end
        take();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] od;
        int ol;
        exp_t e;
        send(4'b0011, 2, 1'b1, 1'b0);
        wait_result(1, od, ol);
        e = sb.pop_front();
        checks++;
        if (od !== e.data || ol !== e.lat) begin
            errors++;
            $display("FAIL bp_result: data=%b lat=%0d, required %b %0d", od, ol, e.data, e.lat);
        end
        for (int k = 0; k < 10; k++) begin
            req_valid = 1'b1;
            req_data  = W'($urandom);
            req_amt   = AMT_W'($urandom);
            req_dir   = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== e.data || req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b data=%b ready=%b busy=%b, required 1 %b 0 1",
                         k, res_valid, res_data, req_ready, busy, e.data);
            end
        end
        req_data = 4'b0001;
        req_amt  = 3'd1;
        req_dir  = 1'b1;
        req_rot  = 1'b0;
        take();
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_accept_on_take: ready=%b valid=%b, required 1 0", req_ready, res_valid);
        end
        sb.push_back('{model_data(4'b0001, 1, 1'b1, 1'b0), model_lat(1, 1'b0)});
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_result(1, od, ol);
        e = sb.pop_front();
        checks++;
        if (od !== e.data || ol !== e.lat) begin
            errors++;
            $display("FAIL bp_next: data=%b lat=%0d, required %b %0d", od, ol, e.data, e.lat);
        end
        take();
    endtask

    task automatic test_reset_mid();
        send(4'b1000, 3, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b data=%b busy=%b, required 1 0 0000 0",
                     req_ready, res_valid, res_data, busy);
        end
        sb.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_case("after_reset", 4'b0101, 2, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            test_case("b2b", W'($urandom), int'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_case("left_1", 4'b0011, 1, 1'b1, 1'b0);
        test_shift_right_busy();
        test_case("amt_zero", 4'b1011, 0, 1'b0, 1'b0);
        test_case("left_7", 4'b1011, 7, 1'b1, 1'b0);
        test_case("rot_r1", 4'b1001, 1, 1'b0, 1'b1);
        test_case("rot_r5", 4'b1001, 5, 1'b0, 1'b1);
        test_case("rot_l3", 4'b1001, 3, 1'b1, 1'b1);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
